// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// alu_seq_if : request/status and accumulator-strobe bundle for alu_seq
// Revision   : 1.0
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] ac_data;
  logic             ac_re;
  logic             ac_we;
  logic             ac_clear;
  logic [WIDTH-1:0] ac_in;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;

  modport master (
    output start, op, operand, ac_data,
    input  ac_re, ac_we, ac_clear, ac_in, busy, done, zero, carry
  );

  modport slave (
    input  start, op, operand, ac_data,
    output ac_re, ac_we, ac_clear, ac_in, busy, done, zero, carry
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq  : multi-cycle ALU sequencer driving the accumulator read/write strobes
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 10
) (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_seq_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_EXEC, S_MUL, S_WRITE, S_DONE, S_CLRS
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   ac_in_q, ac_in_d;
  logic               cpend_q, cpend_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ac_re_q, ac_re_d;
  logic               ac_we_q, ac_we_d;
  logic               ac_clear_q, ac_clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    ac_in_d = ac_in_q;
    cpend_d = cpend_q;
    zero_d  = zero_q;
    carry_d = carry_q;

    sum  = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};
    step = prod_q + (b_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          b_d     = bus.operand;
          state_d = (bus.op == OP_CLR) ? S_CLRS : S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        a_d = bus.ac_data;
        if (op_q == OP_MUL) begin
          mcand_d = {{WIDTH{1'b0}}, bus.ac_data};
          prod_d  = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cpend_d = 1'b0;
        case (op_q)
          OP_ADD: begin ac_in_d = sum[WIDTH-1:0];  cpend_d = sum[WIDTH];  end
          OP_SUB: begin ac_in_d = diff[WIDTH-1:0]; cpend_d = diff[WIDTH]; end
          OP_AND: ac_in_d = a_q & b_q;
          OP_OR:  ac_in_d = a_q | b_q;
          OP_XOR: ac_in_d = a_q ^ b_q;
          OP_SHL: begin ac_in_d = {a_q[WIDTH-2:0], 1'b0}; cpend_d = a_q[WIDTH-1]; end
          default: ;
        endcase
        state_d = S_WRITE;
      end
      // One partial product per cycle, multiplier LSB first.
      S_MUL: begin
        prod_d  = step;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          ac_in_d = step[WIDTH-1:0];
          cpend_d = |step[2*WIDTH-1:WIDTH];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        zero_d  = (ac_in_q == '0);
        carry_d = cpend_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      S_CLRS: begin
        zero_d  = 1'b1;
        carry_d = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    ac_re_d    = (state_d == S_READ);
    ac_we_d    = (state_d == S_WRITE);
    ac_clear_d = (state_d == S_CLRS);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      ac_in_q    <= '0;
      cpend_q    <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      ac_re_q    <= 1'b0;
      ac_we_q    <= 1'b0;
      ac_clear_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      ac_in_q    <= ac_in_d;
      cpend_q    <= cpend_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      ac_re_q    <= ac_re_d;
      ac_we_q    <= ac_we_d;
      ac_clear_q <= ac_clear_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ac_re    = ac_re_q;
  assign bus.ac_we    = ac_we_q;
  assign bus.ac_clear = ac_clear_q;
  assign bus.ac_in    = ac_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;

endmodule
`default_nettype wire
